// File: rtl/octurdle_pkg.sv
// octurdle_pkg: shared display-source encoding and seven-segment constants.
// Used by mux_select (producer of sel_bits) and seg_scan_driver (consumer).
package octurdle_pkg;

    typedef enum logic [1:0] {
        SRC_SCORE  = 2'b00,
        SRC_SWITCH = 2'b01,
        SRC_GAME   = 2'b10,
        SRC_RANDOM = 2'b11
    } disp_src_t;

    // Active-low display: all ones means segments / anodes are off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment glyph.
// Ports:
//   i_hex  [3:0]  nibble to display
//   o_seg  [6:0]  segments {g,f,e,d,c,b,a}, active-low
// b and d use lowercase glyphs so they are distinguishable from 8 and 0.
module hex7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for an 8-digit common-anode
// seven-segment display.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   sel_bits [1:0]    source select (octurdle_pkg::disp_src_t encoding)
//   score_val, switch_val, game_val, random_val [31:0]
//                     eight hex nibbles each, nibble 0 = rightmost digit
//   an  [7:0]         digit anodes, active-low, bit i = digit i
//   seg [6:0]         segments {g,f,e,d,c,b,a}, active-low
//   dp                decimal point, active-low, always off
// The selected source is captured once per frame (cnt==0 && dig==0) so a
// source or select change never tears a frame mid-scan. Each digit slot is
// REFRESH_DIV cycles, of which the first DEAD_CYC have all anodes off.
module seg_scan_driver
    import octurdle_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  sel_bits,
    input  logic [31:0] score_val,
    input  logic [31:0] switch_val,
    input  logic [31:0] game_val,
    input  logic [31:0] random_val,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int              CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   DEAD_LIM = CW'(DEAD_CYC);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_dig;
    disp_src_t     r_frame_sel;
    logic [31:0]   r_frame_val;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_frame_start;
    logic [31:0]   w_src_val;
    logic [31:0]   w_shift;
    logic [3:0]    w_nib;
    logic [6:0]    w_glyph;
    logic          w_lead_zero;
    logic          w_dead;

    assign w_frame_start = (r_cnt == '0) && (r_dig == 3'd0);
    assign w_dead        = (r_cnt < DEAD_LIM);

    always_comb begin
        w_src_val = game_val;
        case (disp_src_t'(sel_bits))
            SRC_SCORE:  w_src_val = score_val;
            SRC_SWITCH: w_src_val = switch_val;
            SRC_GAME:   w_src_val = game_val;
            SRC_RANDOM: w_src_val = random_val;
        endcase
    end

    // Shifting the current digit down to nibble 0 gives both the nibble to
    // decode and, via "everything left is zero", the leading-zero test.
    assign w_shift     = r_frame_val >> {r_dig, 2'b00};
    assign w_nib       = w_shift[3:0];
    assign w_lead_zero = (r_frame_sel == SRC_SCORE) && (r_dig != 3'd0) && (w_shift == '0);

    hex7seg u_hex7seg (
        .i_hex (w_nib),
        .o_seg (w_glyph)
    );

    // Slot counter and digit index; dig wraps 7->0 by its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_dig <= 3'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_dig <= r_dig + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame latch. The load cycle is always a dead-time cycle, so the old
    // frame's value is never shown alongside the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_sel <= SRC_GAME;
            r_frame_val <= '0;
        end else if (w_frame_start) begin
            r_frame_sel <= disp_src_t'(sel_bits);
            r_frame_val <= w_src_val;
        end
    end

    // Registered outputs; blanked leading digits keep their anode asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (w_dead) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(8'h01 << r_dig);
            r_seg <= w_lead_zero ? SEG_BLANK : w_glyph;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, DEAD_CYC=1.
// Each slot is 4 cycles: one dead cycle then three cycles of the digit.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel_bits;
    logic [31:0] score_val;
    logic [31:0] switch_val;
    logic [31:0] game_val;
    logic [31:0] random_val;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_pass  = 0;
    int n_total = 0;

    seg_scan_driver #(
        .REFRESH_DIV (4),
        .DEAD_CYC    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_bits   (sel_bits),
        .score_val  (score_val),
        .switch_val (switch_val),
        .game_val   (game_val),
        .random_val (random_val),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference active-low glyphs {g,f,e,d,c,b,a}
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string tag, input logic [7:0] ean, input logic [6:0] eseg);
        chk({tag, " an"},  32'(an),  32'(ean));
        chk({tag, " seg"}, 32'(seg), 32'(eseg));
        chk({tag, " dp"},  32'(dp),  32'd1);
        chk({tag, " an_onehot"}, 32'($countones(~an) <= 1), 32'd1);
    endtask

    // Steps through slots lo..hi (4 cycles each). blank bit s means digit s
    // is expected with its anode low but all segments off.
    task automatic check_slots(input string tag, input logic [31:0] word,
                               input logic [7:0] blank, input int lo, input int hi);
        logic [7:0]  ean;
        logic [6:0]  eseg;
        logic [31:0] sh;
        for (int s = lo; s <= hi; s++) begin
            for (int ph = 0; ph < 4; ph++) begin
                @(posedge clk);
                @(negedge clk);
                if (ph == 0) begin
                    ean  = 8'hFF;
                    eseg = 7'h7F;
                end else begin
                    ean  = ~(8'h01 << s);
                    sh   = word >> (4 * s);
                    eseg = blank[s] ? 7'h7F : glyph(sh[3:0]);
                end
                chk_outputs($sformatf("%s d%0d p%0d", tag, s, ph), ean, eseg);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        sel_bits   = 2'b10;
        score_val  = 32'h0;
        switch_val = 32'h0;
        game_val   = 32'h8765_4321;
        random_val = 32'h9ABC_DEF0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs("reset", 8'hFF, 7'h7F);

        // Release: first cycle is a frame start, game shows 1..8 and repeats.
        rst_n = 1'b1;
        check_slots("game_f0", 32'h8765_4321, 8'h00, 0, 7);

        // Mid-frame select change at dig=3 stays invisible this frame.
        check_slots("game_f1", 32'h8765_4321, 8'h00, 0, 2);
        sel_bits = 2'b11;
        game_val = 32'h1111_1111;
        check_slots("game_f1", 32'h8765_4321, 8'h00, 3, 7);

        // Random word appears from the next frame; mid-frame edits ignored.
        check_slots("rand_f2", 32'h9ABC_DEF0, 8'h00, 0, 3);
        random_val = 32'hFFFF_FFFF;
        sel_bits   = 2'b00;
        score_val  = 32'h0000_0120;
        check_slots("rand_f2", 32'h9ABC_DEF0, 8'h00, 4, 7);

        // Score 0x120: digits 3..7 blanked, 2/1/0 show 1/2/0.
        check_slots("score_f3", 32'h0000_0120, 8'hF8, 0, 3);
        score_val = 32'h0;
        check_slots("score_f3", 32'h0000_0120, 8'hF8, 4, 7);

        // Zero score: only digit 0 shows "0".
        check_slots("zero_f4", 32'h0, 8'hFE, 0, 3);
        sel_bits   = 2'b01;
        switch_val = 32'h0;
        check_slots("zero_f4", 32'h0, 8'hFE, 4, 7);

        // Switches at 0: no blanking, all digits show "0". Reset at dig=5.
        check_slots("sw_f5", 32'h0, 8'h00, 0, 4);
        @(posedge clk);
        @(negedge clk);
        chk_outputs("sw_f5 d5 p0", 8'hFF, 7'h7F);
        @(posedge clk);
        @(negedge clk);
        chk_outputs("sw_f5 d5 p1", 8'hDF, 7'h40);

        #1 rst_n = 1'b0;
        #1 chk_outputs("async_reset", 8'hFF, 7'h7F);
        sel_bits = 2'b10;
        game_val = 32'hABCD_EF09;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs("held_reset", 8'hFF, 7'h7F);
        rst_n = 1'b1;

        // Scan restarts at digit 0 with freshly latched game value.
        check_slots("game_f6", 32'hABCD_EF09, 8'h00, 0, 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
